// File: rtl/data_sram_like_slave.sv
// ============================================================================
// Module   : data_sram_like_slave
// Brief    : SRAM-like data-port responder with an in-order request queue and
//            byte-lane word RAM. Optional macro: SRAM_SLAVE_STALL_EN (LFSR stall).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_sram_like_slave #(
    parameter int DEPTH_LOG2  = 10,
    parameter int LATENCY     = 2,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] daddr,
    input  logic [31:0] din,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata
);

    localparam int         PTR_W      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int         CNT_W      = $clog2(QUEUE_DEPTH + 1);
    localparam logic [3:0] C_TMR_FIRE = 4'(LATENCY - 1);
    localparam logic [3:0] C_TMR_ACC  = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

    logic [31:0]           mem [2**DEPTH_LOG2];
    logic                  q_wr_q  [QUEUE_DEPTH];
    logic [3:0]            q_be_q  [QUEUE_DEPTH];
    logic [DEPTH_LOG2-1:0] q_idx_q [QUEUE_DEPTH];
    logic [31:0]           q_din_q [QUEUE_DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       timer_q, timer_d;
    logic             data_ok_q, data_ok_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [3:0]            w_be;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_full, w_gate, w_accept, w_bypass, w_fire;
    logic [CNT_W-1:0]      w_pending;
    logic [PTR_W-1:0]      w_cand_ptr;
    logic                  w_cand_wr;
    logic [3:0]            w_cand_be;
    logic [DEPTH_LOG2-1:0] w_cand_idx;
    logic [31:0]           w_cand_din;
    logic                  w_unused;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef SRAM_SLAVE_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        w_gate = lfsr_q[0];
    end
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) lfsr_q <= 8'hA5;
        else         lfsr_q <= lfsr_d;
    end
`else
    assign w_gate = 1'b1;
`endif

    assign w_unused     = ^daddr[31:DEPTH_LOG2+2];
    assign w_idx        = daddr[DEPTH_LOG2+1:2];
    assign w_full       = (count_q == CNT_W'(QUEUE_DEPTH));
    assign data_addr_ok = data_req & ~w_full & w_gate & ~cpu_rst;
    assign w_accept     = data_addr_ok;

    // The entry showing data_data_ok stays in the queue until the end of that
    // cycle, so the next entry to be issued sits one slot behind it.
    assign w_pending  = count_q - CNT_W'(data_ok_q);
    assign w_cand_ptr = data_ok_q ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    assign w_bypass   = (LATENCY == 1) && (w_pending == '0) && w_accept;
    assign w_fire     = ~cpu_rst & (((w_pending != '0) && (timer_q == 4'd0)) || w_bypass);

    always_comb begin
        case (data_size)
            2'b00:   w_be = 4'b0001 << daddr[1:0];
            2'b01:   w_be = daddr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    always_comb begin
        if (w_pending == '0) begin
            w_cand_wr  = data_wr;
            w_cand_be  = w_be;
            w_cand_idx = w_idx;
            w_cand_din = din;
        end else begin
            w_cand_wr  = q_wr_q[w_cand_ptr];
            w_cand_be  = q_be_q[w_cand_ptr];
            w_cand_idx = q_idx_q[w_cand_ptr];
            w_cand_din = q_din_q[w_cand_ptr];
        end
    end

    always_comb begin
        wr_ptr_d  = w_accept  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = data_ok_q ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d   = count_q + CNT_W'(w_accept) - CNT_W'(data_ok_q);
        data_ok_d = w_fire;
        rdata_d   = (w_fire && !w_cand_wr) ? mem[w_cand_idx] : rdata_q;
        // Issue spacing: LATENCY after the previous issue, or LATENCY after
        // acceptance when nothing was waiting.
        if (w_fire)
            timer_d = C_TMR_FIRE;
        else if ((w_pending == '0) && w_accept)
            timer_d = C_TMR_ACC;
        else if (timer_q != 4'd0)
            timer_d = timer_q - 4'd1;
        else
            timer_d = timer_q;
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            timer_q   <= 4'd0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (w_accept) begin
            q_wr_q[wr_ptr_q]  <= data_wr;
            q_be_q[wr_ptr_q]  <= w_be;
            q_idx_q[wr_ptr_q] <= w_idx;
            q_din_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (w_fire && w_cand_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (w_cand_be[k]) mem[w_cand_idx][8*k +: 8] <= w_cand_din[8*k +: 8];
            end
        end
    end

    assign data_data_ok = data_ok_q & ~cpu_rst;
    assign data_rdata   = cpu_rst ? 32'h0 : rdata_q;

endmodule

`default_nettype wire
